mlp_layer_sequencer: RTL

Sequencing controller for the MLP inference datapath. It walks the hidden and output layers neuron-by-neuron, drives read addresses into the input buffer and weight memory, and owns the shared signed MAC accumulator, the Q8.8 rescale and the ReLU/saturate stage. It also holds the hidden activations internally and emits one result per output neuron. It sits between the register front-end (CTRL RUN/DONE, input/weight FIFOs, output register) and the storage.

---
 rtl/mlp_layer_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer: walks the hidden and output layers neuron by neuron,
// issues registered input/weight read addresses, runs the shared signed MAC,
// Q8.8 rescale and ReLU/saturate stage, and emits one result per output neuron.
// Optional build macro: MLP_OUT_RELU_EN applies relu_sat to the output layer;
// without it the output layer is linear with plain truncation.
module mlp_layer_sequencer #(
   parameter int N_INPUTS  = 2,
   parameter int N_HIDDEN  = 4,
   parameter int N_OUTPUT  = 1,
   parameter int IN_WIDTH  = 16,
   parameter int WGT_WIDTH = 16,
   parameter int MAC_WIDTH = 32,
   parameter int OUT_WIDTH = 16,
   parameter int WADDR_W   = $clog2(N_HIDDEN*(N_INPUTS+1) + N_OUTPUT*(N_HIDDEN+1)),
   parameter int IADDR_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic [IADDR_W-1:0]         in_addr,
   input  logic [IN_WIDTH-1:0]        in_data,
   output logic [WADDR_W-1:0]         wgt_addr,
   input  logic [WGT_WIDTH-1:0]       wgt_data,
   output logic                       out_valid,
   output logic [$clog2(N_OUTPUT):0]  out_idx,
   output logic [OUT_WIDTH-1:0]       out_data
);

   localparam int FRAC   = WGT_WIDTH / 2;
   localparam int PROD_W = IN_WIDTH + WGT_WIDTH;
   localparam int OIDX_W = $clog2(N_OUTPUT) + 1;
   localparam int MAXF   = (N_INPUTS > N_HIDDEN) ? N_INPUTS : N_HIDDEN;
   localparam int MAXN   = (N_HIDDEN > N_OUTPUT) ? N_HIDDEN : N_OUTPUT;
   localparam int CNT_W  = (MAXF > 1) ? $clog2(MAXF) : 1;
   localparam int NRN_W  = (MAXN > 1) ? $clog2(MAXN) : 1;
   localparam int HID_IW = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
   localparam logic signed [MAC_WIDTH-1:0] SAT_MAX =
      MAC_WIDTH'((64'd1 << (OUT_WIDTH-1)) - 64'd1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_WB, S_DONE} state_t;

   state_t               state_q, state_d;
   logic                 layer_q, layer_d;        // 0: hidden layer, 1: output layer
   logic [NRN_W-1:0]     nrn_q, nrn_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WADDR_W-1:0]   wgt_addr_q, wgt_addr_d;
   logic [IADDR_W-1:0]   in_addr_q, in_addr_d;

   logic signed [MAC_WIDTH-1:0] acc_q;
   logic signed [IN_WIDTH-1:0]  op_q;
   logic [OUT_WIDTH-1:0]        hid_q [N_HIDDEN];
   logic [OUT_WIDTH-1:0]        out_data_q;
   logic [OIDX_W-1:0]           out_idx_q;

   logic [CNT_W-1:0]            cnt_last;
   logic [NRN_W-1:0]            nrn_last;
   logic signed [WGT_WIDTH-1:0] wgt_s;
   logic signed [IN_WIDTH-1:0]  mul_a;
   logic signed [PROD_W-1:0]    prod_full;
   logic signed [MAC_WIDTH-1:0] prod_ext, bias_ext, sum, shifted, res_sat;
   logic [OUT_WIDTH-1:0]        out_res;

   // Sequencer next-state: neuron/layer walk and registered read addresses.
   always_comb begin
      state_d    = state_q;
      layer_d    = layer_q;
      nrn_d      = nrn_q;
      cnt_d      = cnt_q;
      wgt_addr_d = wgt_addr_q;
      in_addr_d  = in_addr_q;
      cnt_last   = layer_q ? CNT_W'(N_HIDDEN-1) : CNT_W'(N_INPUTS-1);
      nrn_last   = layer_q ? NRN_W'(N_OUTPUT-1) : NRN_W'(N_HIDDEN-1);
      // Weight layout is contiguous, so the bias of each next neuron is last address + 1.
      case (state_q)
         S_IDLE: if (start) begin
            state_d    = S_LOAD;
            layer_d    = 1'b0;
            nrn_d      = '0;
            wgt_addr_d = '0;
            in_addr_d  = '0;
         end
         S_LOAD: begin
            state_d    = S_MAC;
            cnt_d      = '0;
            wgt_addr_d = wgt_addr_q + WADDR_W'(1);
            in_addr_d  = '0;
         end
         S_MAC: if (cnt_q == cnt_last) begin
            state_d = S_WB;
         end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            wgt_addr_d = wgt_addr_q + WADDR_W'(1);
            if (!layer_q) in_addr_d = IADDR_W'(cnt_q + CNT_W'(1));
         end
         S_WB: if (nrn_q == nrn_last && layer_q) begin
            state_d = S_DONE;
         end else begin
            state_d    = S_LOAD;
            wgt_addr_d = wgt_addr_q + WADDR_W'(1);
            if (nrn_q == nrn_last) begin
               layer_d = 1'b1;
               nrn_d   = '0;
            end else begin
               nrn_d   = nrn_q + NRN_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and address registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         layer_q    <= 1'b0;
         nrn_q      <= '0;
         cnt_q      <= '0;
         wgt_addr_q <= '0;
         in_addr_q  <= '0;
      end else begin
         state_q    <= state_d;
         layer_q    <= layer_d;
         nrn_q      <= nrn_d;
         cnt_q      <= cnt_d;
         wgt_addr_q <= wgt_addr_d;
         in_addr_q  <= in_addr_d;
      end
   end

   // MAC datapath: product, rescale, ReLU/saturate and the output-layer result.
   always_comb begin
      wgt_s     = $signed(wgt_data);
      mul_a     = layer_q ? op_q : $signed(in_data);
      prod_full = PROD_W'(mul_a) * PROD_W'(wgt_s);
      prod_ext  = MAC_WIDTH'(prod_full);
      bias_ext  = MAC_WIDTH'(wgt_s) <<< FRAC;
      sum       = acc_q + prod_ext;
      shifted   = sum >>> FRAC;
      if (shifted < 0)            res_sat = '0;
      else if (shifted > SAT_MAX) res_sat = SAT_MAX;
      else                        res_sat = shifted;
`ifdef MLP_OUT_RELU_EN
      out_res   = OUT_WIDTH'(res_sat);
`else
      out_res   = OUT_WIDTH'(shifted);
`endif
   end

   // Accumulator, output-layer operand staging, hidden activations and held result.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q      <= '0;
         op_q       <= '0;
         out_data_q <= '0;
         out_idx_q  <= '0;
         for (int unsigned i = 0; i < N_HIDDEN; i++) hid_q[i] <= '0;
      end else begin
         if (state_q == S_MAC) begin
            acc_q <= (cnt_q == '0) ? bias_ext : sum;
            if (layer_q) op_q <= IN_WIDTH'(hid_q[HID_IW'(cnt_q)]);
         end
         if (state_q == S_WB) begin
            if (!layer_q) begin
               hid_q[HID_IW'(nrn_q)] <= OUT_WIDTH'(res_sat);
            end else begin
               out_data_q <= out_res;
               out_idx_q  <= OIDX_W'(nrn_q);
            end
         end
      end
   end

   // Status and result outputs; strobes are suppressed while reset is asserted.
   always_comb begin
      busy      = (state_q == S_LOAD) || (state_q == S_MAC) || (state_q == S_WB);
      done      = (state_q == S_DONE) && !rst;
      out_valid = (state_q == S_WB) && layer_q && !rst;
      out_data  = out_valid ? out_res : out_data_q;
      out_idx   = out_valid ? OIDX_W'(nrn_q) : out_idx_q;
      in_addr   = in_addr_q;
      wgt_addr  = wgt_addr_q;
   end

endmodule
